// File: rtl/ysyx_22041405_pkg.sv
// ysyx_22041405_pkg: shared IFU state encoding and constants
package ysyx_22041405_pkg;
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2
  } ifu_state_e;
  localparam logic [31:0] RESET_PC = 32'h8000_0000;
  localparam logic [31:0] INST_NOP = 32'h0000_0013;
endpackage

// File: rtl/ysyx_22041405_ifu_fifo.sv
// ysyx_22041405_ifu_fifo: synchronous {inst,pc} FIFO with flush and combinational head read
module ysyx_22041405_ifu_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    flush,
  input  logic                    push,
  input  logic                    pop,
  input  logic [WIDTH-1:0]        push_inst,
  input  logic [WIDTH-1:0]        push_pc,
  output logic [WIDTH-1:0]        head_inst,
  output logic [WIDTH-1:0]        head_pc,
  output logic [$clog2(DEPTH):0]  count
);
  localparam int AW = $clog2(DEPTH);
  logic [WIDTH-1:0] inst_mem [DEPTH];
  logic [WIDTH-1:0] pc_mem [DEPTH];
  logic [AW-1:0] rd, wr;
  always_ff @(posedge clk)
    if (push && !flush) begin
      inst_mem[wr] <= push_inst;
      pc_mem[wr] <= push_pc;
    end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      rd <= '0;
      wr <= '0;
      count <= '0;
    end else if (flush) begin
      rd <= '0;
      wr <= '0;
      count <= '0;
    end else begin
      wr <= wr + AW'(push);
      rd <= rd + AW'(pop);
      count <= count + (AW+1)'(push) - (AW+1)'(pop);
    end
  // empty buffer presents zeros so decode never sees stale entries
  assign head_inst = count != '0 ? inst_mem[rd] : '0;
  assign head_pc = count != '0 ? pc_mem[rd] : '0;
endmodule

// File: rtl/ysyx_22041405_ifu.sv
// ysyx_22041405_ifu: PC, single-outstanding imem fetch FSM and 2-entry instruction buffer.
// Optional performance counters enabled with IFU_PERF_CNT_EN.
module ysyx_22041405_ifu #(
  parameter int               WIDTH      = 32,
  parameter logic [WIDTH-1:0] RESET_PC   = ysyx_22041405_pkg::RESET_PC,
  parameter int               FIFO_DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  output logic             imem_req_valid,
  input  logic             imem_req_ready,
  output logic [WIDTH-1:0] imem_req_addr,
  input  logic             imem_rsp_valid,
  input  logic [WIDTH-1:0] imem_rsp_data,
  input  logic             redirect_valid,
  input  logic [WIDTH-1:0] redirect_pc,
  output logic             inst_valid,
  input  logic             inst_ready,
  output logic [WIDTH-1:0] inst,
  output logic [WIDTH-1:0] inst_pc
`ifdef IFU_PERF_CNT_EN
  ,
  output logic [63:0]      perf_fetch_cnt,
  output logic [31:0]      perf_flush_cnt,
  output logic [31:0]      perf_stall_cnt
`endif
);
  import ysyx_22041405_pkg::*;
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  ifu_state_e state;
  logic [WIDTH-1:0] pc, req_pc, redirect_al;
  logic [CW-1:0] count;
  logic drop, hs, push, pop, space_next;
  assign redirect_al = redirect_pc & ~WIDTH'(3);
  assign hs = imem_req_valid & imem_req_ready;
  assign imem_req_valid = state == REQ;
  assign imem_req_addr = pc;
  assign inst_valid = count != '0;
  assign pop = inst_valid & inst_ready & ~redirect_valid;
  assign push = (state == WAIT) & imem_rsp_valid & ~drop & ~redirect_valid;
  assign space_next = (count + CW'(push) - CW'(pop)) < CW'(FIFO_DEPTH);
  ysyx_22041405_ifu_fifo #(.WIDTH(WIDTH), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk(clk),
    .rst(rst),
    .flush(redirect_valid),
    .push(push),
    .pop(pop),
    .push_inst(imem_rsp_data),
    .push_pc(req_pc),
    .head_inst(inst),
    .head_pc(inst_pc),
    .count(count)
  );
  // a request accepted in the redirect cycle is still in flight, so its response is marked for drop
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state <= IDLE;
      pc <= RESET_PC;
      req_pc <= '0;
      drop <= 1'b0;
    end else if (redirect_valid) begin
      pc <= redirect_al;
      if (state == WAIT) begin
        state <= imem_rsp_valid ? REQ : WAIT;
        drop <= ~imem_rsp_valid;
      end else if (hs) begin
        state <= WAIT;
        drop <= 1'b1;
      end else state <= REQ;
    end else if (state == IDLE) state <= space_next ? REQ : IDLE;
    else if (state == REQ && hs) begin
      req_pc <= pc;
      pc <= pc + WIDTH'(4);
      state <= WAIT;
    end else if (state == WAIT && imem_rsp_valid) begin
      drop <= 1'b0;
      state <= space_next ? REQ : IDLE;
    end
`ifdef IFU_PERF_CNT_EN
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      perf_fetch_cnt <= '0;
      perf_flush_cnt <= '0;
      perf_stall_cnt <= '0;
    end else begin
      if (push && !(&perf_fetch_cnt)) perf_fetch_cnt <= perf_fetch_cnt + 64'd1;
      if (redirect_valid && !(&perf_flush_cnt)) perf_flush_cnt <= perf_flush_cnt + 32'd1;
      if (!inst_valid && state != IDLE && !(&perf_stall_cnt)) perf_stall_cnt <= perf_stall_cnt + 32'd1;
    end
`endif
endmodule
